// File: rtl/jtkiwi_vram_arb_if.sv
// Shared VRAM port signals between the main CPU decode/wait logic, the video scanner and the arbiter.
interface jtkiwi_vram_arb_if;
  logic       cen6;
  logic       LVBL;
  logic       vram_cs;
  logic       vctrl_cs;
  logic       cpu_rnw;
  logic       vid_req;
  logic [7:0] vram_q;
  logic       dev_busy;
  logic       cpu_gnt;
  logic       vram_we;
  logic       vid_gnt;
  logic [7:0] cpu_q;

  modport master (
    output cen6, LVBL, vram_cs, vctrl_cs, cpu_rnw, vid_req, vram_q,
    input  dev_busy, cpu_gnt, vram_we, vid_gnt, cpu_q
  );

  modport slave (
    input  cen6, LVBL, vram_cs, vctrl_cs, cpu_rnw, vid_req, vram_q,
    output dev_busy, cpu_gnt, vram_we, vid_gnt, cpu_q
  );
endinterface

// File: rtl/jtkiwi_vram_arb.sv
// CPU/scanner VRAM arbiter: CPU access takes 4 clocks minimum, MAXWAIT+3 worst case; dev_busy stalls the Z80
// until its slot, scanner yields only during the ACCESS/LATCH pair. Option JTKIWI_VBLANK_FREE_EN: CPU goes straight through in vblank.
module jtkiwi_vram_arb #(
  parameter int MAXWAIT = 32
) (
  input logic              clk,
  input logic              rst_n,
  jtkiwi_vram_arb_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    ACCESS = 3'd2,
    LATCH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [5:0] WAIT_LAST = 6'(MAXWAIT - 1);

  state_t     state;
  logic [5:0] wait_cnt;
  logic       cpu_gnt;
  logic       vram_we;
  logic [7:0] cpu_q;
  logic       cs_any;
  logic       vid_free;

  assign cs_any = bus.vram_cs | bus.vctrl_cs;

`ifdef JTKIWI_VBLANK_FREE_EN
  // The scanner has nothing to fetch in blank, so the CPU never has to wait there.
  assign vid_free    = ~bus.LVBL;
  assign bus.vid_gnt = bus.vid_req & ~cpu_gnt & bus.LVBL;
`else
  logic unused_lvbl;
  assign unused_lvbl = bus.LVBL;
  assign vid_free    = 1'b0;
  assign bus.vid_gnt = bus.vid_req & ~cpu_gnt;
`endif

  // Combinational so the stall reaches the Z80 in the same clock as its chip select.
  assign bus.dev_busy = rst_n & cs_any & (state != DONE);
  assign bus.cpu_gnt  = cpu_gnt;
  assign bus.vram_we  = vram_we;
  assign bus.cpu_q    = cpu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 6'd0;
      cpu_gnt  <= 1'b0;
      vram_we  <= 1'b0;
      cpu_q    <= 8'h00;
    end else begin
      cpu_gnt <= 1'b0;
      vram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_any) begin
            state    <= WAIT;
            wait_cnt <= 6'd0;
          end
        end
        WAIT: begin
          if (!cs_any) begin
            state <= IDLE;
          end else if (!bus.vid_req || vid_free || wait_cnt == WAIT_LAST) begin
            state   <= ACCESS;
            cpu_gnt <= 1'b1;
            vram_we <= ~bus.cpu_rnw;
          end else if (wait_cnt != 6'h3f) begin
            wait_cnt <= wait_cnt + 6'd1;
          end
        end
        ACCESS: begin
          state   <= LATCH;
          cpu_gnt <= 1'b1;
        end
        LATCH: begin
          state <= DONE;
          if (bus.cpu_rnw) cpu_q <= bus.vram_q;
        end
        DONE: begin
          // Exit only on a CPU clock with cs low: one access per Z80 bus cycle.
          if (bus.cen6 && !cs_any) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkiwi_vram_arb.sv
// Directed bench for jtkiwi_vram_arb: per-clock output checks plus a cpu_q scoreboard popped on each DONE entry.
module tb_jtkiwi_vram_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jtkiwi_vram_arb_if bus();

  jtkiwi_vram_arb #(.MAXWAIT(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef JTKIWI_VBLANK_FREE_EN
  localparam int VB_ACC = 2;
  localparam bit VB_FREE = 1'b1;
`else
  localparam int VB_ACC = 33;
  localparam bit VB_FREE = 1'b0;
`endif

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  logic [7:0] last_rd  = 8'h00;
  logic       busy_q   = 1'b0;
  int         gnt_cnt;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample point: mid-cycle. Pops the scoreboard when the DUT enters DONE.
  task automatic sample();
    logic [7:0] exp;
    @(negedge clk);
    if (rst_n && (bus.vram_cs | bus.vctrl_cs) && busy_q && !bus.dev_busy) begin
      chk1("sb.pending", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk8("sb.cpu_q", bus.cpu_q, exp);
      end
    end
    busy_q = bus.dev_busy;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Uncontended access (vid_req=0): fixed 4-clock profile, then one clock of cs low.
  task automatic access(input logic rd, input logic [7:0] d);
    bus.vram_cs = 1'b1;
    bus.cpu_rnw = rd;
    bus.vid_req = 1'b0;
    sb.push_back(rd ? d : last_rd);
    if (rd) last_rd = d;
    for (int c = 0; c < 6; c++) begin
      bus.vram_q = (c == 3) ? (rd ? d : 8'hFF) : 8'h3C;
      sample();
      chk1("acc.busy", bus.dev_busy, c <= 3);
      chk1("acc.we", bus.vram_we, !rd && c == 2);
      chk1("acc.gnt", bus.cpu_gnt, c == 2 || c == 3);
      chk1("acc.vid_gnt", bus.vid_gnt, 1'b0);
      adv();
    end
    bus.vram_cs = 1'b0;
    sample();
    chk1("acc.idle_busy", bus.dev_busy, 1'b0);
    adv();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.cen6     = 1'b1;
    bus.LVBL     = 1'b1;
    bus.vram_cs  = 1'b1;
    bus.vctrl_cs = 1'b0;
    bus.cpu_rnw  = 1'b1;
    bus.vid_req  = 1'b1;
    bus.vram_q   = 8'h3C;

    // Reset values, including dev_busy forced low despite a live chip select.
    sample();
    chk1("rst.busy", bus.dev_busy, 1'b0);
    chk1("rst.gnt", bus.cpu_gnt, 1'b0);
    chk1("rst.we", bus.vram_we, 1'b0);
    chk1("rst.vid_gnt", bus.vid_gnt, 1'b1);
    chk8("rst.cpu_q", bus.cpu_q, 8'h00);
    adv();
    bus.vram_cs = 1'b0;
    bus.vid_req = 1'b0;
    rst_n = 1'b1;
    sample();
    chk1("idle.busy", bus.dev_busy, 1'b0);
    adv();

    // Write, then read, then write that must not disturb cpu_q.
    access(1'b0, 8'h00);
    // Read with scanner holding the port for clocks 1..5.
    bus.vram_cs = 1'b1;
    bus.cpu_rnw = 1'b1;
    sb.push_back(8'hA5);
    last_rd = 8'hA5;
    for (int c = 0; c < 11; c++) begin
      bus.vid_req = (c >= 1 && c <= 5);
      bus.vram_q  = (c == 8) ? 8'hA5 : 8'h3C;
      sample();
      chk1("rd.vid_gnt", bus.vid_gnt, c >= 1 && c <= 5);
      chk1("rd.gnt", bus.cpu_gnt, c == 7 || c == 8);
      chk1("rd.busy", bus.dev_busy, c <= 8);
      chk1("rd.we", bus.vram_we, 1'b0);
      adv();
    end
    bus.vram_cs = 1'b0;
    sample();
    adv();
    access(1'b0, 8'h00);

    // Starvation via the control window: forced grant after MAXWAIT clocks.
    bus.vctrl_cs = 1'b1;
    bus.cpu_rnw  = 1'b1;
    bus.vid_req  = 1'b1;
    sb.push_back(8'h5A);
    last_rd = 8'h5A;
    for (int c = 0; c < 38; c++) begin
      bus.vram_q = (c == 34) ? 8'h5A : 8'h3C;
      sample();
      chk1("starve.gnt", bus.cpu_gnt, c == 33 || c == 34);
      chk1("starve.vid_gnt", bus.vid_gnt, !(c == 33 || c == 34));
      chk1("starve.busy", bus.dev_busy, c <= 34);
      adv();
    end
    bus.vctrl_cs = 1'b0;
    bus.vid_req  = 1'b0;
    sample();
    adv();

    // Reset pulse while a write is waiting behind the scanner.
    bus.vram_cs = 1'b1;
    bus.cpu_rnw = 1'b0;
    bus.vid_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      chk1("rstw.we", bus.vram_we, 1'b0);
      chk1("rstw.busy", bus.dev_busy, 1'b1);
      if (c < 3) adv();
    end
    #2 rst_n = 1'b0;
    #1;
    chk1("rstw.async_busy", bus.dev_busy, 1'b0);
    chk1("rstw.async_gnt", bus.cpu_gnt, 1'b0);
    chk1("rstw.async_we", bus.vram_we, 1'b0);
    chk1("rstw.async_vid_gnt", bus.vid_gnt, 1'b1);
    chk8("rstw.async_cpu_q", bus.cpu_q, 8'h00);
    last_rd = 8'h00;
    adv();
    bus.vram_cs = 1'b0;
    bus.vid_req = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk1("rstw.post_we", bus.vram_we, 1'b0);
      chk1("rstw.post_gnt", bus.cpu_gnt, 1'b0);
      adv();
    end

    // Back-to-back reads separated by one cen6 clock of cs low.
    access(1'b1, 8'h11);
    access(1'b1, 8'h22);

    // One long CPU cycle: a cs dip without cen6 must not start a second access.
    bus.vram_cs = 1'b1;
    bus.cpu_rnw = 1'b1;
    sb.push_back(8'h33);
    last_rd = 8'h33;
    gnt_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      bus.vram_cs = (c != 6);
      bus.cen6    = (c != 6);
      bus.vram_q  = (c == 3) ? 8'h33 : 8'h3C;
      sample();
      if (bus.cpu_gnt) gnt_cnt++;
      adv();
    end
    chk8("long.gnt_clocks", 8'(gnt_cnt), 8'd2);
    bus.vram_cs = 1'b0;
    bus.cen6    = 1'b1;
    sample();
    chk8("long.cpu_q", bus.cpu_q, 8'h33);
    adv();

    // Vertical blank with the scanner requesting.
    bus.LVBL    = 1'b0;
    bus.vram_cs = 1'b1;
    bus.cpu_rnw = 1'b1;
    bus.vid_req = 1'b1;
    sb.push_back(8'h6C);
    last_rd = 8'h6C;
    for (int c = 0; c < VB_ACC + 4; c++) begin
      bus.vram_q = (c == VB_ACC + 1) ? 8'h6C : 8'h3C;
      sample();
      chk1("vb.gnt", bus.cpu_gnt, c == VB_ACC || c == VB_ACC + 1);
      chk1("vb.vid_gnt", bus.vid_gnt, !VB_FREE && !(c == VB_ACC || c == VB_ACC + 1));
      adv();
    end
    bus.vram_cs = 1'b0;
    bus.vid_req = 1'b0;
    bus.LVBL    = 1'b1;
    sample();
    adv();

    chk8("sb.leftover", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
